// File: rtl/ocpi_wsi_pkg.sv
// ocpi_wsi_pkg
// Purpose : shared WSI (streaming write) definitions for the ADC packetizer.
// Contents: MCmd encodings and the WSI field widths.
package ocpi_wsi_pkg;

  localparam int DATA_W = 32;
  localparam int BLEN_W = 12;
  localparam int INFO_W = 8;
  localparam int BE_W   = 4;

  typedef enum logic [2:0] {
    MCMD_IDLE = 3'd0,
    MCMD_WR   = 3'd1
  } mcmd_e;

endpackage

// File: rtl/ocpi_sync_fifo.sv
// ocpi_sync_fifo
// Purpose : single-clock first-word-fall-through FIFO.
// Ports   : clk, rst_n (synchronous active-low, empties the FIFO)
//           push/din  - write when not full, or when full and popping
//           pop/dout  - dout always shows the head word; pop advances it
//           full, empty, count
module ocpi_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A full FIFO still accepts a write in the cycle its head is popped.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wsi_adc_packetizer.sv
// wsi_adc_packetizer
// Purpose : buffers a raw ADC sample stream and emits it as precise WSI
//           write bursts of MSG_WORDS words; drops (and counts) samples
//           arriving while the FIFO is full.
// Ports   : CLK, RST_N (synchronous active-low)
//           enable, clr_stats, adc_valid, adc_data   - control / capture
//           wsi_m_adc_*                              - registered WSI master
//           overrun_cnt, overrun_flag, busy          - status
//
// state | meaning
// IDLE  | no burst open; starts one when data, enable and a ready slave meet
// BURST | burst open; one data beat per cycle when slave ready and FIFO has data
// PAD   | enable dropped mid-burst; drain FIFO, then zero beats until the last
module wsi_adc_packetizer
  import ocpi_wsi_pkg::*;
#(
  parameter int                FIFO_DEPTH = 16,
  parameter int                MSG_WORDS  = 256,
  parameter logic [INFO_W-1:0] OPCODE     = 8'h00
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              enable,
  input  logic              clr_stats,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic [2:0]        wsi_m_adc_MCmd,
  output logic              wsi_m_adc_MReqLast,
  output logic              wsi_m_adc_MBurstPrecise,
  output logic [BLEN_W-1:0] wsi_m_adc_MBurstLength,
  output logic [DATA_W-1:0] wsi_m_adc_MData,
  output logic [BE_W-1:0]   wsi_m_adc_MByteEn,
  output logic [INFO_W-1:0] wsi_m_adc_MReqInfo,
  input  logic              wsi_m_adc_SThreadBusy,
  input  logic              wsi_m_adc_SReset_n,
  output logic              wsi_m_adc_MReset_n,
  output logic [15:0]       overrun_cnt,
  output logic              overrun_flag,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_PAD} state_e;

  localparam logic [BLEN_W-1:0] LAST_BEAT = BLEN_W'(MSG_WORDS - 1);
  localparam logic [BLEN_W-1:0] BURST_LEN = BLEN_W'(MSG_WORDS);

  state_e            state, state_nxt;
  logic [BLEN_W-1:0] beat_cnt, beat_nxt;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_rst_n;
  logic [DATA_W-1:0] fifo_dout;
  logic              launch, pad_beat, capture, overrun;

  // A peer reset flushes the FIFO on the same edge it idles the FSM.
  assign fifo_rst_n = RST_N & wsi_m_adc_SReset_n;
  assign capture    = adc_valid && enable && wsi_m_adc_SReset_n;
  assign fifo_push  = capture && (!fifo_full || fifo_pop);
  assign overrun    = capture && fifo_full && !fifo_pop;
  assign busy       = (state != ST_IDLE);

  ocpi_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (fifo_rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (adc_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count ()
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    fifo_pop  = 1'b0;
    launch    = 1'b0;
    pad_beat  = 1'b0;
    if (!wsi_m_adc_SReset_n) begin
      state_nxt = ST_IDLE;
      beat_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && !fifo_empty && !wsi_m_adc_SThreadBusy) begin
            fifo_pop = 1'b1;
            launch   = 1'b1;
          end
        end
        ST_BURST: begin
          if (!wsi_m_adc_SThreadBusy && !fifo_empty) begin
            fifo_pop = 1'b1;
            launch   = 1'b1;
          end
          if (!enable) state_nxt = ST_PAD;
        end
        ST_PAD: begin
          // Leftover samples go out first; zero beats only once drained.
          if (!wsi_m_adc_SThreadBusy) begin
            launch   = 1'b1;
            fifo_pop = !fifo_empty;
            pad_beat = fifo_empty;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
      if (launch) begin
        if (beat_cnt == LAST_BEAT) begin
          beat_nxt  = '0;
          state_nxt = ST_IDLE;
        end else begin
          beat_nxt = beat_cnt + 1'b1;
          if (state == ST_IDLE) state_nxt = ST_BURST;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wsi_m_adc_MReset_n      <= 1'b0;
      wsi_m_adc_MCmd          <= MCMD_IDLE;
      wsi_m_adc_MReqLast      <= 1'b0;
      wsi_m_adc_MBurstPrecise <= 1'b0;
      wsi_m_adc_MBurstLength  <= '0;
      wsi_m_adc_MData         <= '0;
      wsi_m_adc_MByteEn       <= '0;
      wsi_m_adc_MReqInfo      <= '0;
    end else begin
      wsi_m_adc_MReset_n      <= 1'b1;
      wsi_m_adc_MCmd          <= launch ? MCMD_WR : MCMD_IDLE;
      wsi_m_adc_MReqLast      <= launch && (beat_cnt == LAST_BEAT);
      wsi_m_adc_MBurstPrecise <= launch;
      wsi_m_adc_MBurstLength  <= launch ? BURST_LEN : '0;
      wsi_m_adc_MData         <= (launch && !pad_beat) ? fifo_dout : '0;
      wsi_m_adc_MByteEn       <= (launch && !pad_beat) ? 4'hF : 4'h0;
      wsi_m_adc_MReqInfo      <= launch ? OPCODE : '0;
    end
  end

  // Clear takes priority over a simultaneous drop.
  always_ff @(posedge CLK) begin
    if (!RST_N || clr_stats) begin
      overrun_cnt  <= '0;
      overrun_flag <= 1'b0;
    end else if (overrun) begin
      overrun_flag <= 1'b1;
      if (overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wsi_adc_packetizer.sv
module tb_wsi_adc_packetizer;
  import ocpi_wsi_pkg::*;

  localparam int          MSG = 4;
  localparam logic [7:0]  OPC = 8'hA5;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        enable = 1'b0;
  logic        clr_stats = 1'b0;
  logic        adc_valid = 1'b0;
  logic [31:0] adc_data = '0;
  logic        stb = 1'b0;
  logic        sreset_n = 1'b1;
  logic [2:0]  mcmd;
  logic        mlast, mprec, mreset_n;
  logic [11:0] mblen;
  logic [31:0] mdata;
  logic [3:0]  mbe;
  logic [7:0]  minfo;
  logic [15:0] ovr_cnt;
  logic        ovr_flag, busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  be;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t exp_e;
  logic  mon_en = 1'b0;
  logic  stb_prev = 1'b0;

  wsi_adc_packetizer #(
    .FIFO_DEPTH (16),
    .MSG_WORDS  (MSG),
    .OPCODE     (OPC)
  ) dut (
    .CLK                     (CLK),
    .RST_N                   (RST_N),
    .enable                  (enable),
    .clr_stats               (clr_stats),
    .adc_valid               (adc_valid),
    .adc_data                (adc_data),
    .wsi_m_adc_MCmd          (mcmd),
    .wsi_m_adc_MReqLast      (mlast),
    .wsi_m_adc_MBurstPrecise (mprec),
    .wsi_m_adc_MBurstLength  (mblen),
    .wsi_m_adc_MData         (mdata),
    .wsi_m_adc_MByteEn       (mbe),
    .wsi_m_adc_MReqInfo      (minfo),
    .wsi_m_adc_SThreadBusy   (stb),
    .wsi_m_adc_SReset_n      (sreset_n),
    .wsi_m_adc_MReset_n      (mreset_n),
    .overrun_cnt             (ovr_cnt),
    .overrun_flag            (ovr_flag),
    .busy                    (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every WR beat is matched against the scoreboard queue.
  always @(posedge CLK) stb_prev <= stb;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (stb_prev) chk("idle_after_threadbusy", 32'(mcmd), 32'(MCMD_IDLE));
      if (mcmd == MCMD_WR) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%h required=none", mdata);
        end else begin
          exp_e = exp_q.pop_front();
          chk("beat_data", mdata, exp_e.d);
          chk("beat_byteen", 32'(mbe), 32'(exp_e.be));
          chk("beat_last", 32'(mlast), 32'(exp_e.last));
          chk("beat_len", 32'(mblen), 32'(MSG));
          chk("beat_info", 32'(minfo), 32'(OPC));
          chk("beat_precise", 32'(mprec), 32'd1);
        end
      end else begin
        chk("idle_fields", {8'd0, mprec, mblen, minfo, 3'd0}, 32'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample(input logic [31:0] d);
    adc_valid = 1'b1;
    adc_data  = d;
    cyc();
    adc_valid = 1'b0;
  endtask

  task automatic expect_run(input int first, input int n, input int start_idx);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{d: 32'(first + i), be: 4'hF, last: (((start_idx + i) % MSG) == MSG - 1)});
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      cyc();
    end
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_not_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    // Reset state
    RST_N = 1'b0;
    cyc();
    cyc();
    chk("rst_wsi", {2'd0, mcmd, mlast, mprec, mblen, mbe, minfo, mreset_n}, 32'd0);
    chk("rst_data", mdata, 32'd0);
    chk("rst_stats", {15'd0, ovr_cnt, ovr_flag}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    RST_N = 1'b1;
    cyc();
    chk("mreset_release", 32'(mreset_n), 32'd1);
    mon_en = 1'b1;
    enable = 1'b1;

    // Continuous stream, two back-to-back bursts
    expect_run(1, 8, 0);
    for (int d = 1; d <= 8; d++) sample(32'(d));
    wait_drain("stream");

    // SThreadBusy held three cycles mid-burst
    expect_run(9, 8, 0);
    sample(9); sample(10); sample(11);
    stb = 1'b1;
    sample(12); sample(13); sample(14);
    stb = 1'b0;
    sample(15); sample(16);
    wait_drain("threadbusy");

    // Overrun: 20 samples into a 16-deep FIFO that cannot drain
    stb = 1'b1;
    for (int d = 101; d <= 120; d++) sample(32'(d));
    chk("ovr_cnt_4", 32'(ovr_cnt), 32'd4);
    chk("ovr_flag_set", 32'(ovr_flag), 32'd1);
    clr_stats = 1'b1;
    cyc();
    clr_stats = 1'b0;
    chk("clr_stats", {15'd0, ovr_cnt, ovr_flag}, 32'd0);
    clr_stats = 1'b1;
    adc_valid = 1'b1;
    adc_data  = 32'd999;
    cyc();
    clr_stats = 1'b0;
    adc_valid = 1'b0;
    chk("clr_wins_over_drop", {15'd0, ovr_cnt, ovr_flag}, 32'd0);
    expect_run(101, 16, 0);
    expect_run(121, 4, 0);
    stb = 1'b0;
    sample(121);   // push into a full FIFO on the same edge as the first pop
    sample(122); sample(123); sample(124);
    chk("push_pop_full_no_ovr", {15'd0, ovr_cnt, ovr_flag}, 32'd0);
    wait_drain("overrun");

    // enable drops after beat 2 with the FIFO empty -> two pad beats
    expect_run(201, 2, 0);
    exp_q.push_back('{d: 32'd0, be: 4'h0, last: 1'b0});
    exp_q.push_back('{d: 32'd0, be: 4'h0, last: 1'b1});
    sample(201); sample(202);
    cyc();
    enable = 1'b0;
    cyc();
    chk("pad_busy", 32'(busy), 32'd1);
    wait_drain("pad");
    enable = 1'b1;

    // Peer reset mid-burst flushes FIFO and restarts at beat 0
    expect_run(301, 2, 0);
    sample(301); sample(302);
    cyc();
    stb = 1'b1;
    sample(303); sample(304);
    sreset_n  = 1'b0;
    stb       = 1'b0;
    adc_valid = 1'b1;
    adc_data  = 32'd777;
    cyc();
    chk("peer_rst_mcmd_idle", 32'(mcmd), 32'(MCMD_IDLE));
    chk("peer_rst_busy", 32'(busy), 32'd0);
    cyc();
    sreset_n  = 1'b1;
    adc_valid = 1'b0;
    cyc();
    expect_run(401, 4, 0);
    for (int d = 401; d <= 404; d++) sample(32'(d));
    wait_drain("peer_reset");

    // Full reset mid-burst
    stb = 1'b1;
    for (int d = 501; d <= 517; d++) sample(32'(d));
    chk("pre_rst_ovr_cnt", 32'(ovr_cnt), 32'd1);
    expect_run(501, 2, 0);
    stb = 1'b0;
    cyc();
    cyc();
    RST_N = 1'b0;
    cyc();
    chk("midrst_wsi", {2'd0, mcmd, mlast, mprec, mblen, mbe, minfo, mreset_n}, 32'd0);
    chk("midrst_data", mdata, 32'd0);
    chk("midrst_stats", {15'd0, ovr_cnt, ovr_flag}, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    cyc();
    chk("mreset_held", 32'(mreset_n), 32'd0);
    RST_N = 1'b1;
    cyc();
    chk("mreset_rerelease", 32'(mreset_n), 32'd1);
    expect_run(601, 4, 0);
    for (int d = 601; d <= 604; d++) sample(32'(d));
    wait_drain("post_reset");

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
